// File: rtl/i2s2_adc_rx.sv
// I2S line-in receiver for the Pmod I2S2 (CS5343): generates MCLK/SCLK/LRCK, deserializes SDOUT.
// Define I2S2_RX_RIGHT_EN for stereo capture; when undefined only the left channel is received.
module i2s2_adc_rx #(
    parameter int FRAME_CYCLES = 192,
    parameter int WIDTH        = 24
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    sdout_in,
    output logic                    mclk_out,
    output logic                    lrck_out,
    output logic                    sclk_out,
    output logic signed [WIDTH-1:0] left_out,
    output logic signed [WIDTH-1:0] right_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    overrun_out
);

    localparam logic [7:0] LAST_CNT       = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] HALF_CNT       = 8'(FRAME_CYCLES / 2);
    localparam logic [7:0] LEFT_DONE_CNT  = 8'(4 * WIDTH + 3);
    localparam logic [7:0] RIGHT_DONE_CNT = 8'd3;

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_next_s;
    logic             lrck_r;
    logic             wrapped_r;
    logic             sync1_r;
    logic             sync2_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_next_s;
    logic             sample_s;
    logic             shift_en_s;
    logic             commit_s;
    logic [WIDTH-1:0] left_r;
    logic             valid_r;
    logic             overrun_r;

    assign sample_s     = (cnt_r[1:0] == 2'd3);
    assign shift_next_s = {shift_r[WIDTH-2:0], sync2_r};
    assign commit_s     = (state_r == RUN) &&
`ifdef I2S2_RX_RIGHT_EN
                          (cnt_r == RIGHT_DONE_CNT);
`else
                          (cnt_r == LEFT_DONE_CNT);
`endif

`ifdef I2S2_RX_RIGHT_EN
    logic [WIDTH-1:0] left_hold_r;
    logic [WIDTH-1:0] right_r;

    assign shift_en_s = sample_s;
    assign right_out  = right_r;
`else
    logic [5:0] slot_s;

    // Right-half slots are ignored entirely in the left-only build.
    assign slot_s     = cnt_r[7:2];
    assign shift_en_s = sample_s && (slot_s >= 6'd1) && (slot_s <= 6'(WIDTH));
    assign right_out  = '0;
`endif

    assign mclk_out    = cnt_r[0];
    assign sclk_out    = cnt_r[1];
    assign lrck_out    = lrck_r;
    assign left_out    = left_r;
    assign valid_out   = valid_r;
    assign overrun_out = overrun_r;

    // Frame counter next value, wrapping at the end of the LRCK frame.
    always_comb begin
        cnt_next_s = cnt_r + 8'd1;
        if (cnt_r == LAST_CNT) begin
            cnt_next_s = 8'd0;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
    end

    // PRIME waits out the first full frame so the first pair is never partial.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PRIME: begin
                if (wrapped_r && (cnt_r == RIGHT_DONE_CNT)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PRIME;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = PRIME;
        endcase
    end

    // Timing registers: counter, LRCK, FSM state and first-wrap flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r     <= 8'd0;
            lrck_r    <= 1'b0;
            wrapped_r <= 1'b0;
            state_r   <= PRIME;
        end else begin
            cnt_r   <= cnt_next_s;
            lrck_r  <= (cnt_next_s >= HALF_CNT);
            state_r <= state_next_s;
            if (cnt_r == LAST_CNT) begin
                wrapped_r <= 1'b1;
            end
        end
    end

    // SDOUT synchronizer and MSB-first shift register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            shift_r <= '0;
        end else begin
            sync1_r <= sdout_in;
            sync2_r <= sync1_r;
            if (shift_en_s) begin
                shift_r <= shift_next_s;
            end
        end
    end

    // Output pair, valid/ready handshake and sticky overrun; a commit beats a consume.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            left_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
`ifdef I2S2_RX_RIGHT_EN
            left_hold_r <= '0;
            right_r     <= '0;
`endif
        end else begin
`ifdef I2S2_RX_RIGHT_EN
            if (cnt_r == LEFT_DONE_CNT) begin
                left_hold_r <= shift_next_s;
            end
`endif
            if (commit_s) begin
`ifdef I2S2_RX_RIGHT_EN
                left_r  <= left_hold_r;
                right_r <= shift_next_s;
`else
                left_r  <= shift_next_s;
`endif
                valid_r <= 1'b1;
                if (valid_r && !ready_in) begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && ready_in) begin
                valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s2_adc_rx.sv
// Self-checking bench for i2s2_adc_rx: an ADC model feeds frames and a scoreboard queue holds expected pairs.
module tb_i2s2_adc_rx;

`ifdef I2S2_RX_RIGHT_EN
    localparam int COMMIT_CNT = 3;
    localparam int FIRST_F    = 2;
`else
    localparam int COMMIT_CNT = 99;
    localparam int FIRST_F    = 1;
`endif
    localparam int FIRST_LAT = FIRST_F * 192 + COMMIT_CNT + 1;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        sdout_in;
    logic        ready_in;
    logic        mclk_out, lrck_out, sclk_out, valid_out, overrun_out;
    logic [23:0] left_out, right_out;

    pair_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    pat_mode = 0;
    int    tb_cnt, fidx;

    i2s2_adc_rx #(.FRAME_CYCLES(192), .WIDTH(24)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sdout_in(sdout_in),
        .mclk_out(mclk_out), .lrck_out(lrck_out), .sclk_out(sclk_out),
        .left_out(left_out), .right_out(right_out), .valid_out(valid_out),
        .ready_in(ready_in), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [23:0] left_of(input int f);
        case (pat_mode)
            0:       return 24'h800001;
            1:       return 24'h800000 + 24'(f) * 24'h010101;
            2:       return 24'h123456;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] right_of(input int f);
        case (pat_mode)
            0:       return 24'h7FFFFE;
            1:       return 24'h7FFFFE - 24'(f) * 24'h000303;
            2:       return 24'hABCDEF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference frame position and scoreboard push at each expected commit edge.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tb_cnt <= 0;
            fidx   <= 0;
        end else begin
            if (tb_cnt == COMMIT_CNT && fidx >= FIRST_F) begin
`ifdef I2S2_RX_RIGHT_EN
                exp_q.push_back({left_of(fidx - 1), right_of(fidx - 1)});
`else
                exp_q.push_back({left_of(fidx), 24'h000000});
`endif
            end
            if (tb_cnt == 191) begin
                tb_cnt <= 0;
                fidx   <= fidx + 1;
            end else begin
                tb_cnt <= tb_cnt + 1;
            end
        end
    end

    // ADC model: one bit per slot, changing at the SCLK falling edge, one-bit I2S delay.
    initial begin
        logic [23:0] w;
        int slot;
        sdout_in = 1'b0;
        forever begin
            @(negedge clk_in);
            slot = tb_cnt / 4;
            if (slot == 0) begin
                w = right_of(fidx - 1);
                sdout_in = w[0];
            end else if (slot <= 24) begin
                w = left_of(fidx);
                sdout_in = w[24 - slot];
            end else begin
                w = right_of(fidx);
                sdout_in = w[48 - slot];
            end
        end
    end

    task automatic do_reset(input int mode, input logic rdy);
        rst_n_in = 1'b0;
        pat_mode = mode;
        ready_in = rdy;
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int waited);
        waited = 0;
        while (!valid_out && waited < limit) begin
            @(negedge clk_in);
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if ({mclk_out, sclk_out, lrck_out, valid_out, overrun_out, left_out, right_out} !== 53'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got clk=%b%b%b v=%b o=%b l=%h r=%h, want all zero",
                         mclk_out, sclk_out, lrck_out, valid_out, overrun_out, left_out, right_out);
            end
        end
    endtask

    task automatic test_clocks();
        logic [2:0] want;
        do_reset(0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            want = {tb_cnt[0], tb_cnt[1], (tb_cnt >= 96)};
            n_cmp++;
            if ({mclk_out, sclk_out, lrck_out} !== want) begin
                n_bad++;
                $display("FAIL clocks at cnt %0d: got mclk/sclk/lrck=%b, want %b",
                         tb_cnt, {mclk_out, sclk_out, lrck_out}, want);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_stream();
        int w;
        pair_t p;
        do_reset(0, 1'b1);
        wait_valid(FIRST_LAT + 20, w);
        n_cmp++;
        if (w !== FIRST_LAT) begin
            n_bad++;
            $display("FAIL first_valid_latency: got %0d cycles, want %0d", w, FIRST_LAT);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream_pop %0d: got empty scoreboard, want one pair", k);
            end else begin
                p = exp_q.pop_front();
                if ({left_out, right_out, overrun_out} !== {p.l, p.r, 1'b0}) begin
                    n_bad++;
                    $display("FAIL stream_pair %0d: got l=%h r=%h o=%b, want l=%h r=%h o=0",
                             k, left_out, right_out, overrun_out, p.l, p.r);
                end
            end
            @(negedge clk_in);
            n_cmp++;
            if (valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_consume %0d: got valid=%b, want 0", k, valid_out);
            end
            wait_valid(200, w);
            n_cmp++;
            if (w !== 191) begin
                n_bad++;
                $display("FAIL stream_period %0d: got %0d cycles, want 191", k, w);
            end
        end
    endtask

    task automatic test_overrun();
        int w;
        int unstable;
        pair_t p;
        do_reset(1, 1'b0);
        wait_valid(FIRST_LAT + 20, w);
        p = exp_q.pop_front();
        n_cmp++;
        if ({valid_out, left_out, right_out, overrun_out} !== {1'b1, p.l, p.r, 1'b0}) begin
            n_bad++;
            $display("FAIL overrun_first: got v=%b l=%h r=%h o=%b, want v=1 l=%h r=%h o=0",
                     valid_out, left_out, right_out, overrun_out, p.l, p.r);
        end
        for (int fr = 0; fr < 2; fr++) begin
            unstable = 0;
            for (int i = 0; i < 191; i++) begin
                @(negedge clk_in);
                if ({valid_out, left_out, right_out} !== {1'b1, p.l, p.r}) unstable++;
            end
            n_cmp++;
            if (unstable !== 0) begin
                n_bad++;
                $display("FAIL overrun_hold %0d: got %0d unstable cycles, want 0", fr, unstable);
            end
            @(negedge clk_in);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL overrun_pop %0d: got empty scoreboard, want one pair", fr);
            end else begin
                p = exp_q.pop_front();
                if ({valid_out, left_out, right_out, overrun_out} !== {1'b1, p.l, p.r, 1'b1}) begin
                    n_bad++;
                    $display("FAIL overrun_replace %0d: got v=%b l=%h r=%h o=%b, want v=1 l=%h r=%h o=1",
                             fr, valid_out, left_out, right_out, overrun_out, p.l, p.r);
                end
            end
        end
        ready_in = 1'b1;
        @(negedge clk_in);
        repeat (10) @(negedge clk_in);
        n_cmp++;
        if ({valid_out, overrun_out} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_sticky: got v=%b o=%b, want v=0 o=1", valid_out, overrun_out);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int guard;
        pair_t p;
        do_reset(1, 1'b0);
        wait_valid(FIRST_LAT + 20, w);
        void'(exp_q.pop_front());
        guard = 0;
        @(negedge clk_in);
        while (tb_cnt != COMMIT_CNT && guard < 400) begin
            @(negedge clk_in);
            guard++;
        end
        ready_in = 1'b1;
        @(negedge clk_in);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_pop: got empty scoreboard, want one pair");
        end else begin
            p = exp_q.pop_front();
            if ({valid_out, left_out, right_out, overrun_out} !== {1'b1, p.l, p.r, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_commit: got v=%b l=%h r=%h o=%b, want v=1 l=%h r=%h o=0",
                         valid_out, left_out, right_out, overrun_out, p.l, p.r);
            end
        end
        @(negedge clk_in);
        n_cmp++;
        if ({valid_out, overrun_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_consume: got v=%b o=%b, want v=0 o=0", valid_out, overrun_out);
        end
    endtask

    task automatic test_mid_reset();
        int w;
        int guard;
        pair_t p;
        do_reset(1, 1'b1);
        wait_valid(FIRST_LAT + 20, w);
        guard = 0;
        while (tb_cnt != 150 && guard < 400) begin
            @(negedge clk_in);
            guard++;
        end
        rst_n_in = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({mclk_out, sclk_out, lrck_out, valid_out, overrun_out, left_out, right_out} !== 53'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got clk=%b%b%b v=%b o=%b l=%h r=%h, want all zero",
                     mclk_out, sclk_out, lrck_out, valid_out, overrun_out, left_out, right_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_valid(FIRST_LAT + 20, w);
        n_cmp++;
        if (w !== FIRST_LAT) begin
            n_bad++;
            $display("FAIL midreset_latency: got %0d cycles, want %0d", w, FIRST_LAT);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL midreset_pop: got empty scoreboard, want one pair");
        end else begin
            p = exp_q.pop_front();
            if ({left_out, right_out} !== {p.l, p.r}) begin
                n_bad++;
                $display("FAIL midreset_pair: got l=%h r=%h, want l=%h r=%h",
                         left_out, right_out, p.l, p.r);
            end
        end
    endtask

`ifndef I2S2_RX_RIGHT_EN
    task automatic test_left_only();
        int w;
        do_reset(2, 1'b1);
        wait_valid(FIRST_LAT + 20, w);
        n_cmp++;
        if ({left_out, right_out, valid_out} !== {24'h123456, 24'h000000, 1'b1} || tb_cnt !== 100) begin
            n_bad++;
            $display("FAIL left_only: got l=%h r=%h v=%b at cnt %0d, want l=123456 r=000000 v=1 at cnt 100",
                     left_out, right_out, valid_out, tb_cnt);
        end
    endtask
`endif

    initial begin
        rst_n_in = 1'b0;
        ready_in = 1'b1;
        test_reset();
        test_clocks();
        test_stream();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
`ifndef I2S2_RX_RIGHT_EN
        test_left_only();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
